// File: rtl/regfile_writeback_arbiter_if.sv
// Write-port bus bundle for regfile_writeback_arbiter.
// Groups the issue handshake, the ALU result path, the LSU return handshake
// and the registered register-file write port.
//   master : core side (drives issue/ALU/LSU requests, observes stall/ready/writes)
//   slave  : arbiter side
interface regfile_writeback_arbiter_if #(
    parameter int unsigned DATA_BITS = 8
);
    localparam int unsigned ADDR_BITS = 4;

    // Issue path
    logic                 issue_valid;
    logic                 issue_is_load;
    logic [ADDR_BITS-1:0] issue_rd;
    logic [ADDR_BITS-1:0] issue_rs;
    logic [ADDR_BITS-1:0] issue_rt;
    logic                 issue_stall;

    // ALU result path
    logic                 alu_wr_valid;
    logic [ADDR_BITS-1:0] alu_wr_rd;
    logic [DATA_BITS-1:0] alu_wr_data;

    // LSU load-return handshake
    logic                 lsu_ret_valid;
    logic                 lsu_ret_ready;
    logic [ADDR_BITS-1:0] lsu_ret_rd;
    logic [DATA_BITS-1:0] lsu_ret_data;

    // Register-file write port
    logic                 reg_write_enable;
    logic [ADDR_BITS-1:0] reg_write_address;
    logic [DATA_BITS-1:0] reg_write_data;

    modport master (
        output issue_valid, issue_is_load, issue_rd, issue_rs, issue_rt,
        input  issue_stall,
        output alu_wr_valid, alu_wr_rd, alu_wr_data,
        output lsu_ret_valid, lsu_ret_rd, lsu_ret_data,
        input  lsu_ret_ready,
        input  reg_write_enable, reg_write_address, reg_write_data
    );

    modport slave (
        input  issue_valid, issue_is_load, issue_rd, issue_rs, issue_rt,
        output issue_stall,
        input  alu_wr_valid, alu_wr_rd, alu_wr_data,
        input  lsu_ret_valid, lsu_ret_rd, lsu_ret_data,
        output lsu_ret_ready,
        output reg_write_enable, reg_write_address, reg_write_data
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Per-thread register-file write-port arbiter.
// Shares one write port between the ALU (one-cycle results, always wins) and
// LSU load returns (buffered in a small FIFO, drained when the ALU is idle).
// A pending-load scoreboard flags issue hazards on registers awaiting loads.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   enable       : thread active; 0 freezes all state
//   bus          : slave side of regfile_writeback_arbiter_if
//                  (issue/stall, ALU write, LSU return valid/ready, reg write port)
//   pending_mask : bit n set while Rn awaits load data
//   fifo_count   : LSU FIFO occupancy, 0..LSU_FIFO_DEPTH
//   hazard_error : sticky flag, ALU wrote a register with a load outstanding
module regfile_writeback_arbiter #(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned LSU_FIFO_DEPTH = 4,
    parameter int unsigned WRITABLE_REGS  = 13
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    regfile_writeback_arbiter_if.slave        bus,
    output logic [WRITABLE_REGS-1:0]          pending_mask,
    output logic [$clog2(LSU_FIFO_DEPTH):0]   fifo_count,
    output logic                              hazard_error
);

    localparam int unsigned ADDR_BITS = 4;
    localparam int unsigned REG_SPACE = 16;
    localparam int unsigned PTR_BITS  = $clog2(LSU_FIFO_DEPTH);
    localparam int unsigned CNT_BITS  = PTR_BITS + 1;

    typedef struct packed {
        logic [ADDR_BITS-1:0] rd;
        logic [DATA_BITS-1:0] data;
    } lsu_entry_t;

    // State
    logic [WRITABLE_REGS-1:0] pending_q, pending_d;
    logic                     hazard_q, hazard_d;
    logic                     we_q, we_d;
    logic [ADDR_BITS-1:0]     waddr_q, waddr_d;
    logic [DATA_BITS-1:0]     wdata_q, wdata_d;
    logic [PTR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]      count_q, count_d;
    lsu_entry_t               fifo_mem_q [LSU_FIFO_DEPTH];

    // Combinational nets
    logic [REG_SPACE-1:0]     pend_ext_c;
    logic                     stall_c;
    logic                     ready_c;
    logic                     accept_c;
    logic                     push_c;
    logic                     pop_c;
    logic                     alu_win_c;
    lsu_entry_t               head_c;
    lsu_entry_t               push_entry_c;
    logic [REG_SPACE-1:0]     set_ext_c;
    logic [REG_SPACE-1:0]     clr_ext_c;

    function automatic logic writable(input logic [ADDR_BITS-1:0] a);
        writable = (32'(a) < WRITABLE_REGS);
    endfunction

    function automatic logic [REG_SPACE-1:0] reg_bit(input logic [ADDR_BITS-1:0] a);
        reg_bit = REG_SPACE'(1) << a;
    endfunction

    // Zero-extended mask: read-only addresses index zero bits, so they never match.
    assign pend_ext_c = REG_SPACE'(pending_q);

    // Hazard detection from the registered scoreboard only.
    always_comb begin : stall_comb
        stall_c = bus.issue_valid &
                  (pend_ext_c[bus.issue_rs] | pend_ext_c[bus.issue_rt] | pend_ext_c[bus.issue_rd]);
    end

    // FIFO handshake; ready is held low while reset is asserted.
    always_comb begin : handshake_comb
        ready_c      = reset & enable & (count_q < CNT_BITS'(LSU_FIFO_DEPTH));
        push_c       = bus.lsu_ret_valid & ready_c;
        accept_c     = bus.issue_valid & ~stall_c & enable;
        alu_win_c    = bus.alu_wr_valid & enable;
        head_c       = fifo_mem_q[rd_ptr_q];
        push_entry_c = '{rd: bus.lsu_ret_rd, data: bus.lsu_ret_data};
    end

    // Write-port arbitration, scoreboard update and FIFO bookkeeping.
    always_comb begin : next_state_comb
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        hazard_d  = hazard_q;
        pop_c     = 1'b0;
        set_ext_c = '0;
        clr_ext_c = '0;

        if (alu_win_c) begin
            if (writable(bus.alu_wr_rd)) begin
                we_d    = 1'b1;
                waddr_d = bus.alu_wr_rd;
                wdata_d = bus.alu_wr_data;
                if (pend_ext_c[bus.alu_wr_rd]) begin
                    hazard_d = 1'b1;
                end
            end
        end else if (enable && (count_q != '0)) begin
            // Entries for read-only registers are still consumed, silently.
            pop_c = 1'b1;
            if (writable(head_c.rd)) begin
                we_d      = 1'b1;
                waddr_d   = head_c.rd;
                wdata_d   = head_c.data;
                clr_ext_c = reg_bit(head_c.rd);
            end
        end

        if (accept_c && bus.issue_is_load) begin
            set_ext_c = reg_bit(bus.issue_rd);
        end

        // Set applied after clear so a forced collision leaves the bit set.
        pending_d = (pending_q & ~WRITABLE_REGS'(clr_ext_c)) | WRITABLE_REGS'(set_ext_c);

        wr_ptr_d = wr_ptr_q + PTR_BITS'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_BITS'(pop_c);
        count_d  = count_q + CNT_BITS'(push_c) - CNT_BITS'(pop_c);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            pending_q <= '0;
            hazard_q  <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            hazard_q  <= hazard_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin : fifo_mem
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= push_entry_c;
        end
    end

    assign bus.issue_stall       = stall_c;
    assign bus.lsu_ret_ready     = ready_c;
    assign bus.reg_write_enable  = we_q;
    assign bus.reg_write_address = waddr_q;
    assign bus.reg_write_data    = wdata_q;
    assign pending_mask          = pending_q;
    assign fifo_count            = count_q;
    assign hazard_error          = hazard_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with a write-port scoreboard.
module tb_regfile_writeback_arbiter;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned WREGS     = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WREGS-1:0] pending_mask;
    logic [2:0]       fifo_count;
    logic             hazard_error;

    regfile_writeback_arbiter_if #(.DATA_BITS(DATA_BITS)) bus();

    regfile_writeback_arbiter #(
        .DATA_BITS(DATA_BITS),
        .LSU_FIFO_DEPTH(DEPTH),
        .WRITABLE_REGS(WREGS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bus(bus),
        .pending_mask(pending_mask),
        .fifo_count(fifo_count),
        .hazard_error(hazard_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [3:0] rd, input logic [7:0] d);
        bus.alu_wr_valid = v;
        bus.alu_wr_rd    = rd;
        bus.alu_wr_data  = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [3:0] rd, input logic [7:0] d);
        bus.lsu_ret_valid = v;
        bus.lsu_ret_rd    = rd;
        bus.lsu_ret_data  = d;
    endtask

    task automatic drive_issue(input logic v, input logic ld, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rt);
        bus.issue_valid   = v;
        bus.issue_is_load = ld;
        bus.issue_rd      = rd;
        bus.issue_rs      = rs;
        bus.issue_rt      = rt;
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // Monitor: every write-port strobe must match the next expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.reg_write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", 32'(bus.reg_write_address), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.reg_write_address), 32'(e.addr));
                    check("wr_data", 32'(bus.reg_write_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        drive_alu(1'b0, 4'd0, 8'h00);
        drive_lsu(1'b0, 4'd0, 8'h00);
        drive_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        step();
        step();

        // Reset state
        check("rst_we",      32'(bus.reg_write_enable), 32'd0);
        check("rst_addr",    32'(bus.reg_write_address), 32'd0);
        check("rst_data",    32'(bus.reg_write_data), 32'd0);
        check("rst_pending", 32'(pending_mask), 32'd0);
        check("rst_count",   32'(fifo_count), 32'd0);
        check("rst_hazard",  32'(hazard_error), 32'd0);
        check("rst_ready",   32'(bus.lsu_ret_ready), 32'd0);
        reset  = 1'b1;
        enable = 1'b1;
        #1;
        check("rel_ready", 32'(bus.lsu_ret_ready), 32'd1);

        // ALU write: visible the cycle after, gone the cycle after that
        drive_alu(1'b1, 4'd5, 8'h3C);
        expect_write(4'd5, 8'h3C);
        step();
        check("alu_we_n1",   32'(bus.reg_write_enable), 32'd1);
        check("alu_addr_n1", 32'(bus.reg_write_address), 32'd5);
        check("alu_data_n1", 32'(bus.reg_write_data), 32'h3C);
        drive_alu(1'b0, 4'd0, 8'h00);
        step();
        check("alu_we_n2",   32'(bus.reg_write_enable), 32'd0);
        check("alu_addr_hold", 32'(bus.reg_write_address), 32'd5);

        // Load scoreboard
        drive_issue(1'b1, 1'b1, 4'd2, 4'd0, 4'd0);
        #1;
        check("ldr_stall", 32'(bus.issue_stall), 32'd0);
        step();
        check("ldr_pending", 32'(pending_mask), 32'h004);
        drive_issue(1'b1, 1'b0, 4'd3, 4'd2, 4'd1);
        #1;
        check("add_stall", 32'(bus.issue_stall), 32'd1);
        step();
        check("add_blocked_pending", 32'(pending_mask), 32'h004);
        drive_lsu(1'b1, 4'd2, 8'hA5);
        #1;
        check("ret_ready", 32'(bus.lsu_ret_ready), 32'd1);
        step();
        drive_lsu(1'b0, 4'd0, 8'h00);
        check("ret_count",      32'(fifo_count), 32'd1);
        check("ret_we_early",   32'(bus.reg_write_enable), 32'd0);
        check("ret_stall_held", 32'(bus.issue_stall), 32'd1);
        expect_write(4'd2, 8'hA5);
        step();
        check("ret_we",      32'(bus.reg_write_enable), 32'd1);
        check("ret_pending", 32'(pending_mask), 32'h000);
        check("ret_count0",  32'(fifo_count), 32'd0);
        check("ret_stall",   32'(bus.issue_stall), 32'd0);
        drive_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

        // Port conflict: three ALU writes hold off one queued load return
        drive_alu(1'b1, 4'd1, 8'h11);
        drive_lsu(1'b1, 4'd7, 8'h77);
        expect_write(4'd1, 8'h11);
        step();
        drive_lsu(1'b0, 4'd0, 8'h00);
        check("pc_addr1", 32'(bus.reg_write_address), 32'd1);
        drive_alu(1'b1, 4'd3, 8'h33);
        expect_write(4'd3, 8'h33);
        step();
        check("pc_addr2", 32'(bus.reg_write_address), 32'd3);
        check("pc_count", 32'(fifo_count), 32'd1);
        drive_alu(1'b1, 4'd4, 8'h44);
        expect_write(4'd4, 8'h44);
        step();
        check("pc_addr3", 32'(bus.reg_write_address), 32'd4);
        check("pc_count3", 32'(fifo_count), 32'd1);
        drive_alu(1'b0, 4'd0, 8'h00);
        expect_write(4'd7, 8'h77);
        step();
        check("pc_lsu_we",   32'(bus.reg_write_enable), 32'd1);
        check("pc_lsu_addr", 32'(bus.reg_write_address), 32'd7);
        check("pc_lsu_data", 32'(bus.reg_write_data), 32'h77);
        check("pc_count0",   32'(fifo_count), 32'd0);

        // Full FIFO under continuous ALU writes
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'b1, 4'd6, 8'(8'h60 + i));
            drive_lsu(1'b1, 4'(8 + i), 8'(8'h80 + i));
            expect_write(4'd6, 8'(8'h60 + i));
            step();
            check("fill_count", 32'(fifo_count), 32'(i + 1));
        end
        check("full_ready", 32'(bus.lsu_ret_ready), 32'd0);
        // ALU idle: valid held while full is refused, head pops
        drive_alu(1'b0, 4'd0, 8'h00);
        drive_lsu(1'b1, 4'd12, 8'hC0);
        expect_write(4'd8, 8'h80);
        step();
        check("full_pop_count", 32'(fifo_count), 32'd3);
        check("full_pop_ready", 32'(bus.lsu_ret_ready), 32'd1);
        // Simultaneous push and pop keeps occupancy
        expect_write(4'd9, 8'h81);
        step();
        check("pushpop_count", 32'(fifo_count), 32'd3);
        drive_lsu(1'b0, 4'd0, 8'h00);
        expect_write(4'd10, 8'h82);
        step();
        check("drain_count2", 32'(fifo_count), 32'd2);
        expect_write(4'd11, 8'h83);
        step();
        expect_write(4'd12, 8'hC0);
        step();
        check("drain_count0", 32'(fifo_count), 32'd0);
        check("drain_last_addr", 32'(bus.reg_write_address), 32'd12);

        // Violations
        drive_issue(1'b1, 1'b1, 4'd1, 4'd15, 4'd15);
        step();
        drive_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        check("v_pending", 32'(pending_mask), 32'h002);
        drive_issue(1'b1, 1'b1, 4'd13, 4'd15, 4'd14);
        #1;
        check("v_ro_stall", 32'(bus.issue_stall), 32'd0);
        step();
        drive_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        check("v_ro_pending", 32'(pending_mask), 32'h002);
        drive_alu(1'b1, 4'd1, 8'h99);
        expect_write(4'd1, 8'h99);
        step();
        drive_alu(1'b0, 4'd0, 8'h00);
        check("v_hazard", 32'(hazard_error), 32'd1);
        drive_lsu(1'b1, 4'd14, 8'hEE);
        step();
        drive_lsu(1'b0, 4'd0, 8'h00);
        check("v_r14_count", 32'(fifo_count), 32'd1);
        step();
        check("v_r14_we",      32'(bus.reg_write_enable), 32'd0);
        check("v_r14_count0",  32'(fifo_count), 32'd0);
        check("v_r14_pending", 32'(pending_mask), 32'h002);
        check("v_hazard_stay", 32'(hazard_error), 32'd1);
        drive_lsu(1'b1, 4'd1, 8'h55);
        step();
        drive_lsu(1'b0, 4'd0, 8'h00);
        expect_write(4'd1, 8'h55);
        step();
        check("v_clr_pending", 32'(pending_mask), 32'h000);
        check("v_hazard_sticky", 32'(hazard_error), 32'd1);

        // enable=0 freezes FIFO and ignores the ALU
        drive_alu(1'b1, 4'd6, 8'h66);
        drive_lsu(1'b1, 4'd7, 8'h71);
        expect_write(4'd6, 8'h66);
        step();
        drive_lsu(1'b0, 4'd0, 8'h00);
        enable = 1'b0;
        drive_alu(1'b1, 4'd3, 8'h12);
        #1;
        check("dis_ready", 32'(bus.lsu_ret_ready), 32'd0);
        step();
        check("dis_we",    32'(bus.reg_write_enable), 32'd0);
        check("dis_count", 32'(fifo_count), 32'd1);
        step();
        check("dis_count2", 32'(fifo_count), 32'd1);
        enable = 1'b1;
        drive_alu(1'b0, 4'd0, 8'h00);
        expect_write(4'd7, 8'h71);
        step();
        check("en_addr",  32'(bus.reg_write_address), 32'd7);
        check("en_count", 32'(fifo_count), 32'd0);

        // Reset mid-operation: 3 queued entries, pending 0x007
        for (int i = 0; i < 3; i++) begin
            drive_issue(1'b1, 1'b1, 4'(i), 4'd15, 4'd15);
            drive_alu(1'b1, 4'd4, 8'(8'h40 + i));
            drive_lsu(1'b1, 4'(9 + i), 8'(8'h90 + i));
            expect_write(4'd4, 8'(8'h40 + i));
            step();
        end
        check("mid_count",   32'(fifo_count), 32'd3);
        check("mid_pending", 32'(pending_mask), 32'h007);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_we",      32'(bus.reg_write_enable), 32'd0);
        check("async_addr",    32'(bus.reg_write_address), 32'd0);
        check("async_data",    32'(bus.reg_write_data), 32'd0);
        check("async_pending", 32'(pending_mask), 32'd0);
        check("async_count",   32'(fifo_count), 32'd0);
        check("async_hazard",  32'(hazard_error), 32'd0);
        check("async_ready",   32'(bus.lsu_ret_ready), 32'd0);
        drive_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        drive_alu(1'b0, 4'd0, 8'h00);
        drive_lsu(1'b0, 4'd0, 8'h00);
        step();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("post_ready", 32'(bus.lsu_ret_ready), 32'd1);
        check("post_count", 32'(fifo_count), 32'd0);
        step();
        check("post_we", 32'(bus.reg_write_enable), 32'd0);
        step();

        check("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
